// File: rtl/boot_load_sequencer.sv
// Boot loader: streams words from the SPI flash read engine into imem, holding the core in reset.
// Optional `BOOT_CHECKSUM_EN: reads one extra word after the end marker and checks it against the sum.
module boot_load_sequencer #(
  parameter int          AW        = 10,
  parameter int          MAX_WORDS = 1024,
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter int          TIMEOUT   = 255,
  parameter int          AUTO_BOOT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          boot_start,
  output logic          spi_cmd_valid,
  input  logic          spi_cmd_ready,
  output logic [23:0]   spi_cmd_addr,
  input  logic          spi_rsp_valid,
  input  logic [31:0]   spi_rsp_data,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst_n,
  output logic          prg_mode,
  output logic          boot_err,
  output logic [AW:0]   words_loaded
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WAIT, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [AW:0]   word_idx, word_idx_nxt;
  logic [AW:0]   word_idx_inc;
  logic [TW-1:0] timer, timer_nxt;
  logic [31:0]   data_q, data_nxt;
  logic [AW:0]   words_q, words_nxt;
  logic          first_q;
  logic [AW:0]   rd_idx;
  logic [23:0]   rd_ofs;

`ifdef BOOT_CHECKSUM_EN
  logic          csum_q, csum_nxt;
  logic [31:0]   sum_q, sum_nxt;
  // The checksum word sits one slot past the end marker.
  assign rd_idx = word_idx + (AW+1)'(csum_q);
`else
  assign rd_idx = word_idx;
`endif

  assign word_idx_inc = word_idx + 1'b1;
  assign rd_ofs       = 24'({rd_idx, 2'b00});
  assign spi_cmd_addr = BASE_ADDR + rd_ofs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      word_idx <= '0;
      timer    <= '0;
      data_q   <= '0;
      words_q  <= '0;
      first_q  <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
      csum_q   <= 1'b0;
      sum_q    <= '0;
`endif
    end else begin
      state    <= state_nxt;
      word_idx <= word_idx_nxt;
      timer    <= timer_nxt;
      data_q   <= data_nxt;
      words_q  <= words_nxt;
      first_q  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q   <= csum_nxt;
      sum_q    <= sum_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    word_idx_nxt = word_idx;
    timer_nxt    = timer;
    data_nxt     = data_q;
    words_nxt    = words_q;
`ifdef BOOT_CHECKSUM_EN
    csum_nxt     = csum_q;
    sum_nxt      = sum_q;
`endif
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (boot_start || (state == S_IDLE && AUTO_BOOT != 0 && first_q)) begin
          state_nxt    = S_CMD;
          word_idx_nxt = '0;
`ifdef BOOT_CHECKSUM_EN
          csum_nxt     = 1'b0;
          sum_nxt      = '0;
`endif
        end
      end
      S_CMD: begin
        if (spi_cmd_ready) begin
          state_nxt = S_WAIT;
          timer_nxt = '0;
        end
      end
      S_WAIT: begin
        if (spi_rsp_valid) begin
`ifdef BOOT_CHECKSUM_EN
          if (csum_q) begin
            state_nxt = (spi_rsp_data == sum_q) ? S_DONE : S_ERROR;
            words_nxt = (spi_rsp_data == sum_q) ? word_idx : words_q;
          end else if (spi_rsp_data == END_MARKER) begin
            csum_nxt  = 1'b1;
            state_nxt = S_CMD;
          end else begin
            state_nxt = S_WRITE;
            data_nxt  = spi_rsp_data;
          end
`else
          if (spi_rsp_data == END_MARKER) begin
            state_nxt = S_DONE;
            words_nxt = word_idx;
          end else begin
            state_nxt = S_WRITE;
            data_nxt  = spi_rsp_data;
          end
`endif
        end else if (timer == TW'(TIMEOUT - 1)) begin
          // Error becomes visible TIMEOUT cycles after the command was accepted.
          state_nxt = S_ERROR;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_WRITE: begin
        word_idx_nxt = word_idx_inc;
        state_nxt    = (word_idx_inc == (AW+1)'(MAX_WORDS)) ? S_ERROR : S_CMD;
`ifdef BOOT_CHECKSUM_EN
        sum_nxt      = sum_q + data_q;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign spi_cmd_valid = (state == S_CMD);
  assign imem_we       = (state == S_WRITE);
  assign imem_addr     = word_idx[AW-1:0];
  assign imem_wdata    = data_q;
  assign cpu_rst_n     = (state == S_DONE);
  assign prg_mode      = (state == S_DONE);
  assign boot_err      = (state == S_ERROR);
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_boot_load_sequencer.sv
// Scoreboarded bench: a flash responder model serves reads, expected imem writes are queued per image.
module tb_boot_load_sequencer;
  localparam int          AW   = 10;
  localparam int          MAXW = 4;
  localparam logic [23:0] BASE = 24'hFFFFF8;
  localparam int          TOUT = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          boot_start;
  logic          spi_cmd_valid;
  logic          spi_cmd_ready;
  logic [23:0]   spi_cmd_addr;
  logic          spi_rsp_valid;
  logic [31:0]   spi_rsp_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_n;
  logic          prg_mode;
  logic          boot_err;
  logic [AW:0]   words_loaded;

  boot_load_sequencer #(.AW(AW), .MAX_WORDS(MAXW), .BASE_ADDR(BASE), .TIMEOUT(TOUT), .AUTO_BOOT(1)) dut (
    .clk(clk), .reset(reset), .boot_start(boot_start),
    .spi_cmd_valid(spi_cmd_valid), .spi_cmd_ready(spi_cmd_ready), .spi_cmd_addr(spi_cmd_addr),
    .spi_rsp_valid(spi_rsp_valid), .spi_rsp_data(spi_rsp_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .prg_mode(prg_mode), .boot_err(boot_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_writes = 0;
  logic [63:0] exp_q[$];
  logic [31:0] flash[16];
  bit          ready_en = 1'b1;
  bit          rsp_en = 1'b1;
  time         t_acc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Flash model: three-cycle read latency, one outstanding read.
  initial begin : responder
    int          pend_cnt;
    logic [31:0] pend_data;
    logic [23:0] ofs;
    pend_cnt = 0;
    pend_data = '0;
    spi_cmd_ready = 1'b0;
    spi_rsp_valid = 1'b0;
    spi_rsp_data = '0;
    forever begin
      @(negedge clk);
      spi_rsp_valid = 1'b0;
      if (!reset) pend_cnt = 0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0 && rsp_en) begin
          spi_rsp_valid = 1'b1;
          spi_rsp_data  = pend_data;
        end
      end
      spi_cmd_ready = ready_en;
      if (reset && spi_cmd_valid && ready_en) begin
        ofs       = spi_cmd_addr - BASE;
        pend_data = (ofs[23:2] < 16) ? flash[ofs[5:2]] : 32'hFFFF_FFFF;
        pend_cnt  = 3;
        t_acc     = $time;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && imem_we) begin
      logic [63:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
      n_writes++;
      check("imem_write", {32'(imem_addr), imem_wdata}, e);
    end
  end

  task automatic load_image(input logic [31:0] w0, w1, w2, w3, w4, w5, input int n_exp);
    logic [31:0] w[6];
    logic [31:0] sum;
    w = '{w0, w1, w2, w3, w4, w5};
    sum = '0;
    for (int i = 0; i < 16; i++) flash[i] = (i < 6) ? w[i] : 32'hFFFF_FFFF;
    for (int i = 0; i < n_exp; i++) begin
      exp_q.push_back({32'(i), w[i]});
      sum += w[i];
    end
`ifdef BOOT_CHECKSUM_EN
    flash[n_exp + 1] = sum;
`endif
  endtask

  task automatic pulse_start();
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!(prg_mode || boot_err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ended"}, 64'(prg_mode || boot_err), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_valid"}, 64'(spi_cmd_valid), 64'd0);
    check({tag, "_cmd_addr"}, 64'(spi_cmd_addr), 64'(BASE));
    check({tag, "_imem_we"}, 64'(imem_we), 64'd0);
    check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
    check({tag, "_prg_mode"}, 64'(prg_mode), 64'd0);
    check({tag, "_boot_err"}, 64'(boot_err), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    int n;
    int bad;
    int w0;
    reset = 1'b0;
    boot_start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Auto boot after reset release; image straddles the 24-bit address wrap.
    load_image(32'h11, 32'h22, 32'h33, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
    reset = 1'b1;
    wait_end("auto", 2000);
    check("auto_prg_mode", 64'(prg_mode), 64'd1);
    check("auto_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    check("auto_boot_err", 64'(boot_err), 64'd0);
    check("auto_words", 64'(words_loaded), 64'd3);
    check("auto_q_empty", 64'(exp_q.size()), 64'd0);

    // Restart from DONE: core reset drops as the FSM leaves DONE, reload starts at word 0.
    load_image(32'hAA, 32'hBB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    pulse_start();
    check("rest_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("rest_prg_mode", 64'(prg_mode), 64'd0);
    check("rest_cmd_valid", 64'(spi_cmd_valid), 64'd1);
    check("rest_cmd_addr", 64'(spi_cmd_addr), 64'(BASE));
    wait_end("rest", 2000);
    check("rest_words", 64'(words_loaded), 64'd2);
    check("rest_q_empty", 64'(exp_q.size()), 64'd0);

    // End marker as the very first word.
    load_image(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    w0 = n_writes;
    pulse_start();
    wait_end("mark0", 2000);
    check("mark0_prg_mode", 64'(prg_mode), 64'd1);
    check("mark0_words", 64'(words_loaded), 64'd0);
    check("mark0_no_write", 64'(n_writes - w0), 64'd0);

    // Command held off for 20 cycles: valid/addr stable, no timeout.
    ready_en = 1'b0;
    load_image(32'h5, 32'h6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    pulse_start();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!spi_cmd_valid || spi_cmd_addr !== BASE) bad++;
      @(negedge clk);
    end
    check("hold_stable", 64'(bad), 64'd0);
    check("hold_no_err", 64'(boot_err), 64'd0);
    ready_en = 1'b1;
    wait_end("hold", 2000);
    check("hold_words", 64'(words_loaded), 64'd2);
    check("hold_q_empty", 64'(exp_q.size()), 64'd0);

    // No response: error exactly TIMEOUT cycles after acceptance, then recover.
    rsp_en = 1'b0;
    load_image(32'h7, 32'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    pulse_start();
    wait_end("tout", 600);
    check("tout_boot_err", 64'(boot_err), 64'd1);
    check("tout_cycles", 64'(($time - t_acc) / 10), 64'(TOUT + 1));
    check("tout_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("tout_prg_mode", 64'(prg_mode), 64'd0);
    rsp_en = 1'b1;
    load_image(32'h7, 32'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    pulse_start();
    check("tout_err_clr", 64'(boot_err), 64'd0);
    wait_end("tout_rec", 2000);
    check("tout_rec_prg", 64'(prg_mode), 64'd1);
    check("tout_rec_words", 64'(words_loaded), 64'd2);

    // MAX_WORDS reached without end marker.
    load_image(32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'hFFFF_FFFF, MAXW);
    pulse_start();
    wait_end("ovf", 2000);
    check("ovf_boot_err", 64'(boot_err), 64'd1);
    check("ovf_prg_mode", 64'(prg_mode), 64'd0);
    check("ovf_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset asserted during the first WRITE, then auto reload.
    load_image(32'h9, 32'hA, 32'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
    pulse_start();
    n = 0;
    while (!imem_we && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wrst_saw_write", 64'(imem_we), 64'd1);
    #1 reset = 1'b0;
    #1 check_reset_outputs("wrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    load_image(32'h9, 32'hA, 32'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
    reset = 1'b1;
    wait_end("wrst_rel", 2000);
    check("wrst_prg_mode", 64'(prg_mode), 64'd1);
    check("wrst_words", 64'(words_loaded), 64'd3);
    check("wrst_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
